// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC register, single-outstanding imem req/gnt/rvalid
// master, one-deep instruction buffer toward the core, redirect handling with squash.
module ifetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  output logic            opcode_illegal,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic            discard;
  logic [XLEN-1:0] target_pc;
  logic            opcode_legal;

  assign target_pc = redirect_pc & ~XLEN'(3);

  // discard marks a granted request whose response belongs to a squashed path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      pc       <= RESET_PC;
      discard  <= 1'b0;
      instr    <= NOP_INSTR;
      instr_pc <= RESET_PC;
    end else begin
      case (state)
        S_BOOT: begin
          if (redirect) pc <= target_pc;
          state <= S_REQ;
        end
        S_REQ: begin
          if (redirect) begin
            pc <= target_pc;
            if (imem_gnt) begin
              state   <= S_WAIT;
              discard <= 1'b1;
            end
          end else if (imem_gnt) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            pc <= target_pc;
            if (imem_rvalid) begin
              state   <= S_REQ;
              discard <= 1'b0;
            end else begin
              discard <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              instr    <= imem_rdata;
              instr_pc <= pc;
              pc       <= pc + XLEN'(4);
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect || instr_ready) begin
            if (redirect) pc <= target_pc;
            instr <= NOP_INSTR;
            state <= S_REQ;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_HOLD);
  assign opcode      = instr[6:0];

  always_comb begin
    opcode_legal = 1'b0;
    case (instr[6:0])
      7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011,
      7'b0100011, 7'b0110111, 7'b1101111, 7'b1100111: opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  end

  assign opcode_illegal = instr_valid & ~opcode_legal;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed test-plan scenarios followed by a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic        opcode_illegal;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;

  // Model: next fetch address, one outstanding request (possibly stale), one held instruction
  logic        mBoot, mOut, mStale, mHeld;
  logic [31:0] mPc, mOaddr, mHpc, mHinstr;

  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .opcode(opcode),
    .opcode_illegal(opcode_illegal),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic legalOp(input logic [6:0] op);
    logic [6:0] tbl [8];
    tbl = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0110111, 7'b1101111, 7'b1100111};
    legalOp = 1'b0;
    foreach (tbl[i]) if (tbl[i] == op) legalOp = 1'b1;
  endfunction

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s cycle %0d: observed %h expected %h", tag, cycle, obs, exp);
    end
  endtask

  task automatic modelReset();
    mBoot = 1'b1; mOut = 1'b0; mStale = 1'b0; mHeld = 1'b0;
    mPc = 32'h0; mOaddr = 32'h0; mHpc = 32'h0; mHinstr = NOP;
  endtask

  task automatic updateModel();
    logic req;
    req = !mBoot && !mOut && !mHeld;
    if (mBoot) begin
      mBoot = 1'b0;
      if (redirect) mPc = redirect_pc & ~32'h3;
    end else if (redirect) begin
      mPc = redirect_pc & ~32'h3;
      if (req && imem_gnt) begin
        mOut = 1'b1; mStale = 1'b1;
      end else if (mOut) begin
        if (imem_rvalid) mOut = 1'b0;
        else mStale = 1'b1;
      end
      mHeld = 1'b0;
    end else if (req && imem_gnt) begin
      mOut = 1'b1; mStale = 1'b0; mOaddr = mPc;
    end else if (mOut && imem_rvalid) begin
      mOut = 1'b0;
      if (!mStale) begin
        mHeld = 1'b1; mHpc = mOaddr; mHinstr = imem_rdata; mPc = mOaddr + 32'd4;
      end
    end else if (mHeld && instr_ready) begin
      mHeld = 1'b0;
    end
  endtask

  task automatic checkOutput();
    logic        expReq;
    logic [31:0] ei;
    expReq = !mBoot && !mOut && !mHeld;
    ei = mHeld ? mHinstr : NOP;
    expectEq("imem_req", {31'b0, imem_req}, {31'b0, expReq});
    if (expReq) expectEq("imem_addr", imem_addr, mPc);
    expectEq("instr_valid", {31'b0, instr_valid}, {31'b0, mHeld});
    expectEq("instr", instr, ei);
    expectEq("opcode", {25'b0, opcode}, {25'b0, ei[6:0]});
    expectEq("opcode_illegal", {31'b0, opcode_illegal}, {31'b0, mHeld && !legalOp(ei[6:0])});
    if (mHeld) expectEq("instr_pc", instr_pc, mHpc);
  endtask

  task automatic applyStimulus(input logic g, input logic rv, input logic [31:0] rd,
                               input logic rdy, input logic rdr, input logic [31:0] rp);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    instr_ready = rdy; redirect = rdr; redirect_pc = rp;
    @(posedge clk);
    updateModel();
    @(negedge clk);
    cycle++;
    checkOutput();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    expectEq("rst_imem_req", {31'b0, imem_req}, 32'h0);
    expectEq("rst_imem_addr", imem_addr, 32'h0);
    expectEq("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    expectEq("rst_instr", instr, NOP);
    expectEq("rst_instr_pc", instr_pc, 32'h0);
    expectEq("rst_illegal", {31'b0, opcode_illegal}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    @(negedge clk);
    doReset();

    // Basic fetch with immediate grant, one-cycle rvalid, ready high
    applyStimulus(1, 0, 0, 1, 0, 0);
    expectEq("first_addr", imem_addr, 32'h0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 32'h0050_0093, 1, 0, 0);
    expectEq("first_instr", instr, 32'h0050_0093);
    expectEq("first_opcode", {25'b0, opcode}, 32'h13);
    expectEq("first_illegal", {31'b0, opcode_illegal}, 32'h0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    expectEq("second_addr", imem_addr, 32'h4);

    // Core stalls for five cycles
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h0010_0113, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    expectEq("after_stall_addr", imem_addr, 32'h8);

    // Redirect coincident with grant for 0x8
    applyStimulus(1, 0, 0, 1, 1, 32'h200);
    applyStimulus(0, 1, 32'h1234_5678, 1, 0, 0);
    expectEq("redir_gnt_addr", imem_addr, 32'h200);

    // Redirect while waiting, then stale response
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 32'h103);
    applyStimulus(0, 1, 32'hDEAD_BEEF, 1, 0, 0);
    expectEq("redir_wait_valid", {31'b0, instr_valid}, 32'h0);
    expectEq("redir_wait_addr", imem_addr, 32'h100);

    // Unsupported opcode
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h0000_007F, 0, 0, 0);
    expectEq("illegal_flag", {31'b0, opcode_illegal}, 32'h1);
    expectEq("illegal_opcode", {25'b0, opcode}, 32'h7F);
    applyStimulus(0, 0, 0, 1, 0, 0);
    expectEq("illegal_cleared", {31'b0, opcode_illegal}, 32'h0);

    // PC wrap at top of address space
    applyStimulus(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 32'h0000_0033, 1, 0, 0);
    expectEq("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 1, 0, 0);
    expectEq("wrap_addr", imem_addr, 32'h0);

    // Reset while waiting; a late rvalid in BOOT is ignored
    applyStimulus(1, 0, 0, 1, 0, 0);
    doReset();
    applyStimulus(0, 1, 32'h0000_0063, 1, 0, 0);
    expectEq("refetch_addr", imem_addr, 32'h0);

    // Randomized traffic, including stray rvalid and unaligned redirect targets
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) == 0,
                    ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 255), 5'b0, 7'b0010011},
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 9) == 0,
                    ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
